forward_unit: RTL and testbench

FORWARD_UNIT -- requirements
Module: forward_unit

---
 rtl/forward_unit.sv | 100 ++++++++++
 tb/tb_forward_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/forward_unit.sv
// -----------------------------------------------------------------------------
// forward_unit
//   Data-hazard forwarding unit for a 5-stage pipeline. It selects the ALU
//   operand sources for the instruction in EX and can optionally count how
//   often each forwarding path is used.
//
//   Optional feature macro: FORWARD_UNIT_STATS_EN
//     defined   -> MemFwdCount / WbFwdCount are saturating cycle counters
//     undefined -> no counter registers; both counts read 0, clk/rst unused
//
// Ports
//   clk          in   1      system clock (rising edge)
//   rst          in   1      asynchronous active-high reset (counters only)
//   MEMRegRd     in   5      destination register of EX/MEM instruction
//   WBRegRd      in   5      destination register of MEM/WB instruction
//   EXRegRs      in   5      Rs source of the EX instruction
//   EXRegRt      in   5      Rt source of the EX instruction
//   MEM_RegWrite in   1      EX/MEM instruction writes the register file
//   WB_RegWrite  in   1      MEM/WB instruction writes the register file
//   ForwardA     out  2      operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   ForwardB     out  2      operand B select, same encoding
//   MemFwdCount  out  CNT_W  cycles with any EX/MEM forward
//   WbFwdCount   out  CNT_W  cycles with any MEM/WB forward
// -----------------------------------------------------------------------------
module forward_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       MEMRegRd,
    input  logic [4:0]       WBRegRd,
    input  logic [4:0]       EXRegRs,
    input  logic [4:0]       EXRegRt,
    input  logic             MEM_RegWrite,
    input  logic             WB_RegWrite,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic [CNT_W-1:0] MemFwdCount,
    output logic [CNT_W-1:0] WbFwdCount
);

    // Select for one ALU operand. The WB path is blocked whenever MEMRegRd
    // names the same source, even if the EX/MEM instruction does not write;
    // this mirrors the original pipeline and is intentional.
    function automatic logic [1:0] fwdSel(input logic [4:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (MEM_RegWrite && (MEMRegRd != 5'd0) && (MEMRegRd == src)) begin
            sel = 2'b10;
        end else if (WB_RegWrite && (WBRegRd != 5'd0) && (WBRegRd == src)
                     && (MEMRegRd != src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        ForwardA = fwdSel(EXRegRs);
        ForwardB = fwdSel(EXRegRt);
    end

`ifdef FORWARD_UNIT_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] memCountReg;
    logic [CNT_W-1:0] wbCountReg;
    logic             memHit;
    logic             wbHit;

    // One count per cycle, no matter how many operands use the path.
    assign memHit = (ForwardA == 2'b10) || (ForwardB == 2'b10);
    assign wbHit  = (ForwardA == 2'b01) || (ForwardB == 2'b01);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memCountReg <= '0;
            wbCountReg  <= '0;
        end else begin
            if (memHit && (memCountReg != CNT_MAX)) begin
                memCountReg <= memCountReg + CNT_ONE;
            end
            if (wbHit && (wbCountReg != CNT_MAX)) begin
                wbCountReg <= wbCountReg + CNT_ONE;
            end
        end
    end

    assign MemFwdCount = memCountReg;
    assign WbFwdCount  = wbCountReg;
`else
    // Statistics disabled: clock and reset intentionally unused.
    logic unusedClkRst;
    assign unusedClkRst = clk ^ rst;

    assign MemFwdCount = '0;
    assign WbFwdCount  = '0;
`endif

endmodule

// File: tb/tb_forward_unit.sv
// -----------------------------------------------------------------------------
// tb_forward_unit
//   Directed + random checks of forward_unit. Expected mux selects are pushed
//   to a scoreboard queue when a vector is driven and popped when the outputs
//   are sampled. Counter expectations come from a small reference model that
//   follows the counting rules (saturating, async reset) when
//   FORWARD_UNIT_STATS_EN is defined, and is constant 0 otherwise.
// -----------------------------------------------------------------------------
module tb_forward_unit;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [4:0]       MEMRegRd = '0;
    logic [4:0]       WBRegRd = '0;
    logic [4:0]       EXRegRs = '0;
    logic [4:0]       EXRegRt = '0;
    logic             MEM_RegWrite = 1'b0;
    logic             WB_RegWrite = 1'b0;
    logic [1:0]       ForwardA;
    logic [1:0]       ForwardB;
    logic [CNT_W-1:0] MemFwdCount;
    logic [CNT_W-1:0] WbFwdCount;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
    } exp_t;
    exp_t sbQueue[$];

    logic [CNT_W-1:0] modelMem;
    logic [CNT_W-1:0] modelWb;

    forward_unit #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .MEMRegRd    (MEMRegRd),
        .WBRegRd     (WBRegRd),
        .EXRegRs     (EXRegRs),
        .EXRegRt     (EXRegRt),
        .MEM_RegWrite(MEM_RegWrite),
        .WB_RegWrite (WB_RegWrite),
        .ForwardA    (ForwardA),
        .ForwardB    (ForwardB),
        .MemFwdCount (MemFwdCount),
        .WbFwdCount  (WbFwdCount)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] refSel(input logic [4:0] memRd, input logic memWr,
                                          input logic [4:0] wbRd, input logic wbWr,
                                          input logic [4:0] src);
        if (memWr && memRd != 0 && memRd == src) return 2'b10;
        if (wbWr && wbRd != 0 && wbRd == src && memRd != src) return 2'b01;
        return 2'b00;
    endfunction

    // Counter reference model.
    always @(posedge clk or posedge rst) begin : cntModel
        logic [1:0] a, b;
        if (rst) begin
            modelMem <= '0;
            modelWb  <= '0;
        end else begin
`ifdef FORWARD_UNIT_STATS_EN
            a = refSel(MEMRegRd, MEM_RegWrite, WBRegRd, WB_RegWrite, EXRegRs);
            b = refSel(MEMRegRd, MEM_RegWrite, WBRegRd, WB_RegWrite, EXRegRt);
            if ((a == 2'b10 || b == 2'b10) && modelMem != CNT_MAX) modelMem <= modelMem + 1'b1;
            if ((a == 2'b01 || b == 2'b01) && modelWb != CNT_MAX) modelWb <= modelWb + 1'b1;
`else
            a = 2'b00;
            b = 2'b00;
            modelMem <= '0;
            modelWb  <= '0;
`endif
        end
    end

    task automatic driveVec(input logic [4:0] memRd, input logic [4:0] wbRd,
                            input logic [4:0] rs, input logic [4:0] rt,
                            input logic memWr, input logic wbWr);
        exp_t e;
        MEMRegRd = memRd; WBRegRd = wbRd; EXRegRs = rs; EXRegRt = rt;
        MEM_RegWrite = memWr; WB_RegWrite = wbWr;
        e.fa = refSel(memRd, memWr, wbRd, wbWr, rs);
        e.fb = refSel(memRd, memWr, wbRd, wbWr, rt);
        sbQueue.push_back(e);
    endtask

    task automatic checkFwd(input string tag);
        exp_t e;
        checks++;
        assert (sbQueue.size() > 0) else begin
            errors++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
            return;
        end
        e = sbQueue.pop_front();
        $display("step %s: A=%b B=%b (exp A=%b B=%b)", tag, ForwardA, ForwardB, e.fa, e.fb);
        assert ({ForwardA, ForwardB} === {e.fa, e.fb}) else begin
            errors++;
            $error("FAIL %s fwd observed=%b/%b expected=%b/%b", tag, ForwardA, ForwardB, e.fa, e.fb);
        end
        checks++;
        assert (ForwardA !== 2'b11 && ForwardB !== 2'b11) else begin
            errors++;
            $error("FAIL %s illegal11 observed=%b/%b expected=not 11", tag, ForwardA, ForwardB);
        end
    endtask

    task automatic checkCnt(input string tag);
        checks++;
        $display("cnt %s: mem=%0d wb=%0d (exp %0d %0d)", tag, MemFwdCount, WbFwdCount, modelMem, modelWb);
        assert (MemFwdCount === modelMem && WbFwdCount === modelWb) else begin
            errors++;
            $error("FAIL %s counts observed=%0d/%0d expected=%0d/%0d",
                   tag, MemFwdCount, WbFwdCount, modelMem, modelWb);
        end
    endtask

    // Fixed-value check for the directed spec examples (independent of refSel).
    task automatic checkConst(input string tag, input logic [1:0] fa, input logic [1:0] fb);
        checks++;
        assert (ForwardA === fa && ForwardB === fb) else begin
            errors++;
            $error("FAIL %s const observed=%b/%b expected=%b/%b", tag, ForwardA, ForwardB, fa, fb);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [CNT_W-1:0] expMem;
        // Reset state (async, before any clock edge).
        #2;
        checkCnt("reset");
        driveVec(5'd1, 5'd1, 5'd1, 5'd0, 1'b1, 1'b1);
        #1;
        checkFwd("fwd_in_reset");
        checkConst("fwd_in_reset_c", 2'b10, 2'b00);
        nextCycle();
        checkCnt("hold_in_reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed examples.
        nextCycle();
        driveVec(5'd1, 5'd1, 5'd1, 5'd0, 1'b1, 1'b1); #1;
        checkFwd("mem_priority"); checkConst("mem_priority_c", 2'b10, 2'b00);
        nextCycle(); checkCnt("after_mem");
        driveVec(5'd0, 5'd1, 5'd1, 5'd0, 1'b0, 1'b1); #1;
        checkFwd("wb_a"); checkConst("wb_a_c", 2'b01, 2'b00);
        nextCycle();
        driveVec(5'd0, 5'd1, 5'd1, 5'd1, 1'b0, 1'b1); #1;
        checkFwd("wb_ab"); checkConst("wb_ab_c", 2'b01, 2'b01);
        nextCycle(); checkCnt("after_wb");
        driveVec(5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1); #1;
        checkFwd("reg0"); checkConst("reg0_c", 2'b00, 2'b00);
        nextCycle();
        driveVec(5'd3, 5'd3, 5'd3, 5'd0, 1'b0, 1'b1); #1;
        checkFwd("wb_suppress"); checkConst("wb_suppress_c", 2'b00, 2'b00);
        driveVec(5'd2, 5'd2, 5'd2, 5'd2, 1'b1, 1'b1); #1;
        checkFwd("both_mem"); checkConst("both_mem_c", 2'b10, 2'b10);
        driveVec(5'd4, 5'd7, 5'd7, 5'd4, 1'b1, 1'b1); #1;
        checkFwd("mixed"); checkConst("mixed_c", 2'b01, 2'b10);
        nextCycle(); checkCnt("after_mixed");

        // Pulse reset, then three cycles of EX/MEM forwarding.
        rst = 1'b1; #1; checkCnt("pulse_rst");
        driveVec(5'd1, 5'd1, 5'd1, 5'd0, 1'b1, 1'b1); #1;
        checkFwd("stat_vec");
        @(negedge clk); rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkCnt("three_cycles");
`ifdef FORWARD_UNIT_STATS_EN
        expMem = 3;
`else
        expMem = 0;
`endif
        checks++;
        assert (MemFwdCount === expMem && WbFwdCount === '0) else begin
            errors++;
            $error("FAIL three_abs observed=%0d/%0d expected=%0d/0", MemFwdCount, WbFwdCount, expMem);
        end
        // Asynchronous reset mid-cycle clears immediately.
        #2; rst = 1'b1; #1;
        checkCnt("async_rst");
        checks++;
        assert (MemFwdCount === '0 && WbFwdCount === '0) else begin
            errors++;
            $error("FAIL async_abs observed=%0d/%0d expected=0/0", MemFwdCount, WbFwdCount);
        end
        @(negedge clk); rst = 1'b0;

        // Saturation: both paths active for well over 2^CNT_W cycles.
        driveVec(5'd5, 5'd6, 5'd5, 5'd6, 1'b1, 1'b1); #1;
        checkFwd("sat_vec");
        repeat (2 * (1 << CNT_W) + 3) @(posedge clk);
        #1;
        checkCnt("saturate");

        // Random vectors over a narrow register range to get plenty of matches.
        for (int i = 0; i < 300; i++) begin
            nextCycle();
            driveVec(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            #1;
            checkFwd($sformatf("rand%0d", i));
        end
        for (int i = 0; i < 100; i++) begin
            nextCycle();
            driveVec(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                     1'($urandom), 1'($urandom));
            #1;
            checkFwd($sformatf("wide%0d", i));
        end
        nextCycle();
        checkCnt("random_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
